// File: rtl/interlaken_metaframe_sync.sv
// Interlaken receive meta-frame synchroniser: hunts for the sync word, tracks alignment,
// strips framing words and exports the scrambler state. Optional counter: INTERLAKEN_SYNC_ERR_CNT_EN.
module interlaken_metaframe_sync #(
    parameter int unsigned METAFRAME_LEN = 2048,
    parameter int unsigned LOCK_CNT      = 4,
    parameter int unsigned UNLOCK_CNT    = 4
) (
    input  logic        USER_CLK,
    input  logic        SYSTEM_RESET_N,
    input  logic [63:0] DATA_IN,
    input  logic [1:0]  HEADER_IN,
    input  logic        WORD_LOCKED,
    output logic [63:0] DATA_OUT,
    output logic [1:0]  HEADER_OUT,
    output logic        VALID_OUT,
    output logic        FRAME_LOCKED,
    output logic [57:0] SCRAM_STATE_OUT,
    output logic        SCRAM_STATE_VALID,
    output logic        HDR_ERR
`ifdef INTERLAKEN_SYNC_ERR_CNT_EN
    ,
    output logic [15:0] SYNC_ERR_CNT
`endif
);

    localparam logic [63:0] SYNC_WORD = 64'h78F678F678F678F6;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pos_q, pos_d;
    logic [7:0]  good_q, good_d;
    logic [7:0]  bad_q, bad_d;

    logic [63:0] data_q, data_d;
    logic [1:0]  hdr_q, hdr_d;
    logic        valid_q, valid_d;
    logic        locked_q, locked_d;
    logic [57:0] scram_q, scram_d;
    logic        scram_vld_q, scram_vld_d;
    logic        hdr_err_q, hdr_err_d;
`ifdef INTERLAKEN_SYNC_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [16:0] err_sum;
    logic        miss_evt;
`endif

    logic        is_ctrl, is_sync, is_scram, is_skip, is_diag, is_framing, hdr_bad;
    logic [15:0] pos_adv;

    assign is_ctrl    = (HEADER_IN == 2'b10);
    assign is_sync    = is_ctrl && (DATA_IN == SYNC_WORD);
    assign is_scram   = is_ctrl && (DATA_IN[63:58] == 6'b001010);
    assign is_skip    = is_ctrl && (DATA_IN[63:58] == 6'b000111);
    assign is_diag    = is_ctrl && (DATA_IN[63:58] == 6'b011001);
    assign is_framing = is_sync || is_scram || is_skip || is_diag;
    assign hdr_bad    = (HEADER_IN == 2'b00) || (HEADER_IN == 2'b11);
    assign pos_adv    = (pos_q == 16'(METAFRAME_LEN - 1)) ? 16'd0 : pos_q + 16'd1;

    // State register: FSM, alignment counters and all registered outputs.
    always_ff @(posedge USER_CLK) begin
        if (!SYSTEM_RESET_N) begin
            state_q     <= HUNT;
            pos_q       <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            data_q      <= '0;
            hdr_q       <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            scram_q     <= '0;
            scram_vld_q <= 1'b0;
            hdr_err_q   <= 1'b0;
`ifdef INTERLAKEN_SYNC_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pos_q       <= pos_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            data_q      <= data_d;
            hdr_q       <= hdr_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            scram_q     <= scram_d;
            scram_vld_q <= scram_vld_d;
            hdr_err_q   <= hdr_err_d;
`ifdef INTERLAKEN_SYNC_ERR_CNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    // Next-state logic; loss of word lock overrides every other transition.
    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        good_d  = good_q;
        bad_d   = bad_q;
        if (!WORD_LOCKED) begin
            state_d = HUNT;
            pos_d   = '0;
            good_d  = '0;
            bad_d   = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    pos_d = '0;
                    if (is_sync) begin
                        state_d = VERIFY;
                        pos_d   = 16'd1;
                        good_d  = 8'd1;
                    end
                end
                VERIFY: begin
                    pos_d = pos_adv;
                    if (pos_q == 16'd0) begin
                        if (is_sync) begin
                            good_d = good_q + 8'd1;
                            if (good_q + 8'd1 == 8'(LOCK_CNT)) begin
                                state_d = LOCKED;
                                bad_d   = '0;
                            end
                        end else begin
                            state_d = HUNT;
                            pos_d   = '0;
                            good_d  = '0;
                            bad_d   = '0;
                        end
                    end
                end
                LOCKED: begin
                    pos_d = pos_adv;
                    if (pos_q == 16'd0) begin
                        if (is_sync) begin
                            bad_d = '0;
                        end else if (bad_q + 8'd1 == 8'(UNLOCK_CNT)) begin
                            state_d = HUNT;
                            pos_d   = '0;
                            good_d  = '0;
                            bad_d   = '0;
                        end else begin
                            bad_d = bad_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    pos_d   = '0;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end
    end

    // Output logic: classification of the current word, registered one cycle later.
    always_comb begin
        data_d      = DATA_IN;
        hdr_d       = HEADER_IN;
        valid_d     = (state_q == LOCKED) && WORD_LOCKED &&
                      ((HEADER_IN == 2'b01) || (is_ctrl && !is_framing));
        locked_d    = (state_q == LOCKED);
        scram_d     = scram_q;
        scram_vld_d = 1'b0;
        hdr_err_d   = hdr_bad;
        if (is_scram && (state_q != HUNT)) begin
            scram_d     = DATA_IN[57:0];
            scram_vld_d = 1'b1;
        end
`ifdef INTERLAKEN_SYNC_ERR_CNT_EN
        miss_evt  = (state_q == LOCKED) && WORD_LOCKED && (pos_q == 16'd0) && !is_sync;
        err_sum   = {1'b0, err_cnt_q} + 17'(miss_evt) + 17'(hdr_bad);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
`endif
    end

    assign DATA_OUT          = data_q;
    assign HEADER_OUT        = hdr_q;
    assign VALID_OUT         = valid_q;
    assign FRAME_LOCKED      = locked_q;
    assign SCRAM_STATE_OUT   = scram_q;
    assign SCRAM_STATE_VALID = scram_vld_q;
    assign HDR_ERR           = hdr_err_q;
`ifdef INTERLAKEN_SYNC_ERR_CNT_EN
    assign SYNC_ERR_CNT      = err_cnt_q;
`endif

endmodule
